// File: rtl/map_inflation_pkg.sv
// Shared definitions for the map-inflation datapath blocks.
//   DEF_DATA_WIDTH / DEF_KERNEL_SIZE : default beat width and row count
//   lane_idx_w()                     : width of a lane index for k lanes
//   occ_t                            : 2-bit lane FIFO occupancy (0, 1 or 2)
package map_inflation_pkg;

    localparam int DEF_DATA_WIDTH  = 18;
    localparam int DEF_KERNEL_SIZE = 3;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // At least one bit, so a degenerate single-lane build still has a sel register.
    function automatic int lane_idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/distributor_lane_fifo.sv
// Two-entry lane buffer for row_distributor. The head register drives the
// output directly, so dout/valid are pure registered state.
//   clk, rst : clock, synchronous active-high reset
//   push     : write din this cycle (never asserted while full)
//   din      : incoming entry (data, plus tlast bit when enabled)
//   ready    : downstream ready; a pop happens on valid && ready
//   valid    : lane holds at least one entry
//   full     : lane holds two entries
//   dout     : head entry
module distributor_lane_fifo
    import map_inflation_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ready,
    output logic                  valid,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout
);

    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign valid = (occ != OCC_EMPTY);
    assign full  = (occ == OCC_FULL);
    assign dout  = head;
    assign pop   = valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        occ  <= OCC_ONE;
                        head <= din;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            occ  <= OCC_FULL;
                            tail <= din;
                        end
                        // Simultaneous push and pop: new beat replaces the head, no bubble.
                        2'b11: head <= din;
                        2'b01: occ  <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_FULL: begin
                    if (pop) begin
                        occ  <= OCC_ONE;
                        head <= tail;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/row_distributor.sv
// Round-robin distributor: one AXI-Stream input dealt beat by beat to
// KERNEL_SIZE row lanes, each buffered by a 2-entry FIFO. Input ready comes
// only from registered lane state, never from any m_axis_tready.
// Optional feature macro: DISTRIBUTOR_TLAST_EN (adds tlast ports/storage;
// a beat with tlast=1 returns the lane pointer to 0).
//   clk, rst                       : clock, synchronous active-high reset
//   s_axis_tvalid/tdata/tready     : input stream
//   s_axis_tlast                   : input end-of-frame (TLAST build only)
//   m_axis_tvalid/tdata/tready     : per-lane outputs, lane i at bit i /
//                                    tdata[i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tlast                   : per-lane last flag (TLAST build only)
module row_distributor
    import map_inflation_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
`ifdef DISTRIBUTOR_TLAST_EN
    input  logic                              s_axis_tlast,
`endif
    output logic                              s_axis_tready,
    output logic [KERNEL_SIZE-1:0]            m_axis_tvalid,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_axis_tdata,
`ifdef DISTRIBUTOR_TLAST_EN
    output logic [KERNEL_SIZE-1:0]            m_axis_tlast,
`endif
    input  logic [KERNEL_SIZE-1:0]            m_axis_tready
);

    localparam int SEL_W = lane_idx_w(KERNEL_SIZE);
`ifdef DISTRIBUTOR_TLAST_EN
    localparam int LANE_W = DATA_WIDTH + 1;
`else
    localparam int LANE_W = DATA_WIDTH;
`endif

    logic [SEL_W-1:0]                    sel;
    logic [SEL_W-1:0]                    sel_nxt;
    logic                                sel_full;
    logic                                fire;
    logic [KERNEL_SIZE-1:0]              lane_full;
    logic [KERNEL_SIZE-1:0]              lane_push;
    logic [LANE_W-1:0]                   lane_din;
    logic [KERNEL_SIZE-1:0][LANE_W-1:0]  lane_dout;

`ifdef DISTRIBUTOR_TLAST_EN
    assign lane_din = {s_axis_tlast, s_axis_tdata};
`else
    assign lane_din = s_axis_tdata;
`endif

    // Compare-based lane select keeps sel values >= KERNEL_SIZE out of range
    // of any vector index.
    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (sel == SEL_W'(i)) sel_full = lane_full[i];
        end
    end

    assign s_axis_tready = !rst && !sel_full;
    assign fire          = s_axis_tvalid && s_axis_tready;

    always_comb begin
        lane_push = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (sel == SEL_W'(i)) lane_push[i] = fire;
        end
    end

    always_comb begin
        sel_nxt = sel;
        if (fire) begin
            if (sel == SEL_W'(KERNEL_SIZE - 1)) sel_nxt = '0;
            else                                sel_nxt = sel + SEL_W'(1);
`ifdef DISTRIBUTOR_TLAST_EN
            // End of frame realigns the next frame to row 0.
            if (s_axis_tlast) sel_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sel <= '0;
        else     sel <= sel_nxt;
    end

    for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
        distributor_lane_fifo #(
            .DATA_WIDTH (LANE_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .push  (lane_push[i]),
            .din   (lane_din),
            .ready (m_axis_tready[i]),
            .valid (m_axis_tvalid[i]),
            .full  (lane_full[i]),
            .dout  (lane_dout[i])
        );

        assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = lane_dout[i][DATA_WIDTH-1:0];
`ifdef DISTRIBUTOR_TLAST_EN
        assign m_axis_tlast[i] = lane_dout[i][DATA_WIDTH];
`endif
    end

endmodule

// File: tb/tb_row_distributor.sv
// Testbench for row_distributor: directed scenarios plus a randomized run,
// checked by a per-lane scoreboard fed from a round-robin reference model.
module tb_row_distributor;

    localparam int K  = 3;
    localparam int DW = 18;
    localparam int EW = DW + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic [DW-1:0]      s_data = '0;
    logic               s_last = 1'b0;
    logic               s_ready;
    logic [K-1:0]       m_valid;
    logic [DW*K-1:0]    m_data;
    logic [K-1:0]       m_last;
    logic [K-1:0]       m_ready = '1;

    int checks = 0;
    int failures = 0;
    int stalls = 0;

    logic [EW-1:0] exp_q [K][$];
    int            msel = 0;
    logic          rst_edge = 1'b0;
    logic [DW-1:0] lane_data [K];

    always #5 clk = ~clk;

    row_distributor #(.KERNEL_SIZE(K), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
`ifdef DISTRIBUTOR_TLAST_EN
        .s_axis_tlast  (s_last),
`endif
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
`ifdef DISTRIBUTOR_TLAST_EN
        .m_axis_tlast  (m_last),
`endif
        .m_axis_tready (m_ready)
    );

`ifndef DISTRIBUTOR_TLAST_EN
    assign m_last = '0;
`endif

    always_comb begin
        for (int i = 0; i < K; i++) lane_data[i] = m_data[i*DW +: DW];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_edge <= rst;

    // Scoreboard monitor: samples mid-cycle what the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(s_ready), 32'd0);
            if (rst_edge) begin
                chk("rst_valid", 32'(m_valid), 32'd0);
                chk("rst_data", m_data[31:0], 32'd0);
                chk("rst_data_hi", 32'(m_data[DW*K-1:32]), 32'd0);
                chk("rst_last", 32'(m_last), 32'd0);
            end
            for (int i = 0; i < K; i++) exp_q[i].delete();
            msel = 0;
        end else begin
            bit pre_full;
            pre_full = (exp_q[msel].size() >= 2);
            chk("in_ready", 32'(s_ready), 32'(!pre_full));
            for (int i = 0; i < K; i++) begin
                chk($sformatf("lane%0d_valid", i), 32'(m_valid[i]), 32'(exp_q[i].size() != 0));
                if (m_valid[i] && exp_q[i].size() != 0) begin
                    chk($sformatf("lane%0d_beat", i), 32'({m_last[i], lane_data[i]}),
                        32'(exp_q[i][0]));
                    if (m_ready[i]) void'(exp_q[i].pop_front());
                end
            end
            if (s_valid && s_ready) begin
                checks++;
                assert (!pre_full) else begin
                    failures++;
                    $display("FAIL push_into_full: lane %0d already holds 2", msel);
                end
`ifdef DISTRIBUTOR_TLAST_EN
                exp_q[msel].push_back({s_last, s_data});
                msel = s_last ? 0 : (msel + 1) % K;
`else
                exp_q[msel].push_back({1'b0, s_data});
                msel = (msel + 1) % K;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the beat until accepted; leaves s_valid high for back-to-back streams.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        bit fired;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        forever begin
            @(negedge clk);
            fired = s_ready;
            step();
            if (fired) break;
            stalls++;
            n++;
            if (n > 300) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    bit rnd_done;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: straight round-robin, all lanes draining
        m_ready = '1;
        stalls = 0;
        for (int d = 1; d <= 6; d++) send(DW'(d), 1'b0);
        chk("t1_no_stall", 32'(stalls), 32'd0);
        idle(3);

        // 2: lane 1 held off; input stalls when its turn comes, then resumes in order
        m_ready = 3'b101;
        fork
            begin
                for (int d = 10; d <= 17; d++) send(DW'(d), 1'b0);
            end
            begin
                repeat (14) step();
                chk("t2_stalled", 32'(s_ready), 32'd0);
                chk("t2_lane1_head", 32'(lane_data[1]), 32'd11);
                chk("t2_lane1_valid", 32'(m_valid[1]), 32'd1);
                m_ready[1] = 1'b1;
            end
        join
        idle(4);
        send(DW'(99), 1'b0);   // realign pointer to lane 0
        idle(3);

        // 3: push and pop on lane 0 at occupancy 1 in the same cycle
        m_ready = 3'b110;
        send(DW'(20), 1'b0);
        send(DW'(21), 1'b0);
        send(DW'(22), 1'b0);
        m_ready[0] = 1'b1;
        send(DW'(7), 1'b0);
        s_valid = 1'b0;
        chk("t3_lane0_valid", 32'(m_valid[0]), 32'd1);
        chk("t3_lane0_head", 32'(lane_data[0]), 32'd7);
        idle(3);

        // 4: reset with lanes holding data
        m_ready = '0;
        send(DW'(30), 1'b0);
        send(DW'(31), 1'b0);
        send(DW'(32), 1'b0);
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("t4_valid", 32'(m_valid), 32'd0);
        chk("t4_data", m_data[31:0], 32'd0);
        chk("t4_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        send(18'h3FFFF, 1'b0);
        s_valid = 1'b0;
        chk("t4_lane0_valid", 32'(m_valid[0]), 32'd1);
        chk("t4_lane0_data", 32'(lane_data[0]), 32'h3FFFF);
        m_ready = '1;
        idle(3);

`ifdef DISTRIBUTOR_TLAST_EN
        // 5: tlast realigns the pointer to lane 0
        do_reset();
        m_ready = '0;
        send(DW'(10), 1'b0);
        send(DW'(11), 1'b1);
        send(DW'(12), 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t5_lane0_head", 32'(lane_data[0]), 32'd10);
        chk("t5_lane1_head", 32'(lane_data[1]), 32'd11);
        chk("t5_lane1_last", 32'(m_last[1]), 32'd1);
        chk("t5_lane2_valid", 32'(m_valid[2]), 32'd0);
        m_ready = 3'b001;
        step();
        chk("t5_lane0_second", 32'(lane_data[0]), 32'd12);
        m_ready = '1;
        idle(3);
`endif

        // 6: random beats against random per-lane ready
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(DW'($urandom), 1'(($urandom_range(7) == 0)));
                end
                s_valid = 1'b0;
                s_last  = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    m_ready = K'($urandom);
                end
            end
        join
        m_ready = '1;
        idle(10);
        for (int i = 0; i < K; i++)
            chk($sformatf("drain_lane%0d", i), 32'(exp_q[i].size()), 32'd0);
        chk("drain_valid", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
